// File: rtl/chunked_seq_adder_if.sv
// Start/done handshake and operand/result bus for chunked_seq_adder.
// master drives requests, slave (the adder) returns status and result.
interface chunked_seq_adder_if #(
  parameter int unsigned WIDTH = 16
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin, sub,
    input  ready, busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output ready, busy, done, sum, cout, ovf
  );

endinterface

// File: rtl/chunked_seq_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit ripple stage reused over WIDTH/CHUNK cycles,
// carry registered between slices, result published on a one-cycle done pulse.
module chunked_seq_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input logic               clk,
  input logic               rst,
  chunked_seq_adder_if.slave bus
);

  localparam int unsigned NumChunks = WIDTH / CHUNK;
  localparam int unsigned CntW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NumChunks - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] chunk_s;
  logic             chunk_co;
  logic             msb_ci;
  logic [WIDTH-1:0] res_new;

  // Slice select driven by the chunk counter; constant indices keep the mux static.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int unsigned i = 0; i < NumChunks; i++) begin
      if (cnt_q == CntW'(i)) begin
        a_chunk = a_q[i*CHUNK +: CHUNK];
        b_chunk = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  assign {chunk_co, chunk_s} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};

  // Carry into the top bit of the slice recovered from its sum and operand bits.
  assign msb_ci = chunk_s[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1];

  always_comb begin
    res_new = res_q;
    for (int unsigned i = 0; i < NumChunks; i++) begin
      if (cnt_q == CntW'(i)) begin
        res_new[i*CHUNK +: CHUNK] = chunk_s;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? ~bus.cin : bus.cin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        res_d   = res_new;
        carry_d = chunk_co;
        if (cnt_q == LastCnt) begin
          sum_d   = res_new;
          cout_d  = chunk_co;
          ovf_d   = msb_ci ^ chunk_co;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    ready_d = (state_d == StIdle);
    busy_d  = (state_d == StRun);
    done_d  = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: doc/chunked_seq_adder.md
Name: chunked_seq_adder

Overview:
- Parametrised multi-cycle adder/subtractor; next generation of the team's 4-bit ripple-carry adder.
- Operands are WIDTH bits wide. Each cycle, one CHUNK-bit slice is processed through a single CHUNK-bit ripple-carry stage, with the carry registered between slices.
- Start/done handshake lets a narrow, cheap adder serve wide datapath operands in the arithmetic units.

Parameters:
- WIDTH, 16: operand and result width. Must be a multiple of CHUNK.
- CHUNK, 4: bits added per cycle, i.e. the ripple-stage width. CHUNK == WIDTH is legal and gives a 1-cycle run.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request. Accepted only when ready=1.
- a  input  WIDTH  operand A, sampled at accept.
- b  input  WIDTH  operand B, sampled at accept.
- cin  input  1  carry-in for add, borrow-in for subtract. Sampled at accept.
- sub  input  1  0 = add, 1 = subtract. Sampled at accept.
- ready  output  1  high in IDLE only.
- busy  output  1  high in RUN.
- done  output  1  one-cycle completion pulse.
- sum  output  WIDTH  result. Held until the next completion.
- cout  output  1  raw carry out of the MSB of the adder.
- ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset, asynchronous:
  - state=IDLE, ready=1, busy=0, done=0, sum=0, cout=0, ovf=0.
  - Internal operand registers, chunk counter and carry register are cleared.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - ready=1.
  - On a clock edge with start=1, latch the operands:
    - A_reg = a.
    - B_reg = sub ? ~b : b.
    - carry = sub ? ~cin : cin.
    - cnt = 0.
  - Go to RUN.
  - start=0 stays in IDLE.
- RUN:
  - busy=1, ready=0. start is ignored; no queueing.
  - Each edge adds chunk cnt (bits cnt*CHUNK .. cnt*CHUNK+CHUNK-1) of A_reg, B_reg and carry:
    - The CHUNK-bit result goes into the matching slice of the internal result register.
    - The chunk carry-out goes into carry.
    - cnt increments.
  - On the edge that processes the last chunk (cnt = WIDTH/CHUNK - 1), also capture:
    - cout = final carry.
    - ovf = carry into MSB XOR carry out of MSB.
    - The sum output register.
  - Then go to DONE.
- DONE:
  - done=1 for exactly one cycle; ready=0, busy=0.
  - Next edge returns to IDLE. A start asserted during DONE is ignored.
- Latency:
  - Accept edge E0. Chunks are processed on E1..E(WIDTH/CHUNK).
  - sum/cout/ovf update on E(WIDTH/CHUNK). done is high in the cycle following that edge.
  - For defaults: done is high 4 cycles after accept. Next accept is possible 6 edges after the previous one (throughput: one op per WIDTH/CHUNK+2 cycles).
- Arithmetic:
  - Add: sum = (a + b + cin) mod 2^WIDTH.
  - Subtract: sum = (a - b - cin) mod 2^WIDTH.
  - cout is the raw adder carry. For subtract, cout=1 means no borrow.
  - ovf is valid for both modes.
- Output hold: sum/cout/ovf do not change during RUN. They change only at completion, so the previous result stays readable while a new op is running.
- Reset mid-RUN: the op is aborted, no done pulse, and outputs return to 0 immediately (asynchronously).
- Inputs a/b/cin/sub may change freely after the accept edge without effect.

Test Plan (WIDTH=16, CHUNK=4 unless stated):
1. Add 9+2, cin=0 -> done exactly 4 cycles after accept; sum=0x000B, cout=0, ovf=0.
2. Add 0xFFFF+0xFFFF, cin=1 -> sum=0xFFFF, cout=1, ovf=0. Add 0x7FFF+0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1.
3. Subtract 0x0005-0x0007, cin=0 -> sum=0xFFFE, cout=0, ovf=0. Subtract 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1.
4. Pulse start with a=1, b=1 two cycles into a 9+9 op -> second request ignored; single done; sum=0x0012. Previous sum is held throughout RUN.
5. Assert rst mid-RUN -> outputs 0 immediately; no done; ready=1 after release. A following 10+5 op gives sum=0x000F.
6. WIDTH=8, CHUNK=8: add 0xF0+0x10 -> done 1 cycle after accept; sum=0x00, cout=1, ovf=0.
